// File: rtl/regfile_wb_writer.sv
// Write-side front end of the 32x32 register file: arbitrates ALU results and buffered load
// returns onto the single write port, and tracks outstanding writes. Optional macro: WB_FORWARD_EN.
module regfile_wb_writer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     reserve_valid,
    input  logic [ADDR_W-1:0]        reserve_addr,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic                     rf_write_enable,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic [DATA_W-1:0]        rf_data_in,
`ifdef WB_FORWARD_EN
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
`endif
    output logic [1:0]               occ_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              full;
    logic              empty;
    logic              alu_fire;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic              win_valid;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_write;
    logic [NREG-1:0]   pending_next;

    // Handshakes: a transfer happens on a posedge where valid && ready are both high; ready is
    // combinational and never depends on valid. A producer seeing ready low holds valid and payload.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign alu_ready = rst_n && !full;
    assign mem_ready = rst_n && !full;
    assign alu_fire  = alu_valid && alu_ready;
    assign push      = mem_valid && mem_ready;
    // A full buffer takes the write slot away from the ALU so loads cannot starve.
    assign pop       = rst_n && !empty && (full || !alu_valid);
    assign head      = fifo_mem[rd_ptr];

    // Occupancy FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Occupancy FSM: next state.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Occupancy FSM: state decode for observation.
    always_comb begin
        occ_state = OCC_PARTIAL;
        if (empty) begin
            occ_state = OCC_EMPTY;
        end else if (full) begin
            occ_state = OCC_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {mem_addr, mem_data};
        end
    end

    always_comb begin
        win_valid = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        if (alu_fire) begin
            win_valid = 1'b1;
            win_addr  = alu_addr;
            win_data  = alu_data;
        end else if (pop) begin
            win_valid = 1'b1;
            win_addr  = head[ENT_W-1:DATA_W];
            win_data  = head[DATA_W-1:0];
        end
    end

    // x0 results are consumed but never reach the regfile.
    assign win_write = win_valid && (win_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_data_in      <= '0;
        end else begin
            rf_write_enable <= win_write;
            if (win_write) begin
                rf_write_addr <= win_addr;
                rf_data_in    <= win_data;
            end
        end
    end

    // Retire clears on the registered write; a same-cycle reserve of that register wins.
    always_comb begin
        pending_next = pending;
        if (rf_write_enable) begin
            pending_next[rf_write_addr] = 1'b0;
        end
        if (reserve_valid) begin
            pending_next[reserve_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_hit  = rf_write_enable && (rf_write_addr == fwd_addr) && (fwd_addr != '0);
    assign fwd_data = rf_data_in;
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Self-checking bench for regfile_wb_writer: directed scenarios plus randomized traffic,
// scored against a queue-based reference model of the write-back rules.
module tb_regfile_wb_writer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREG  = 1 << AW;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic              alu_ready;
    logic [AW-1:0]     alu_addr;
    logic [DW-1:0]     alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data;
    logic              reserve_valid;
    logic [AW-1:0]     reserve_addr;
    logic [NREG-1:0]   pending;
    logic              rf_write_enable;
    logic [AW-1:0]     rf_write_addr;
    logic [DW-1:0]     rf_data_in;
    logic [1:0]        occ_state;
`ifdef WB_FORWARD_EN
    logic [AW-1:0]     fwd_addr;
    logic              fwd_hit;
    logic [DW-1:0]     fwd_data;
`endif

    regfile_wb_writer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_addr        (alu_addr),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .reserve_valid   (reserve_valid),
        .reserve_addr    (reserve_addr),
        .pending         (pending),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_data_in      (rf_data_in),
`ifdef WB_FORWARD_EN
        .fwd_addr        (fwd_addr),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data),
`endif
        .occ_state       (occ_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mq[$];
    logic [NREG-1:0]  m_pending  = '0;
    logic             m_cur_we   = 1'b0;
    logic [AW-1:0]    m_cur_addr = '0;
    logic [DW-1:0]    m_cur_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one write slot per cycle, ALU first unless the load buffer is full.
    always @(posedge clk) begin : model
        logic [AW+DW-1:0] w;
        bit have;
        bit mfull;
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_pending = '0;
            m_cur_we  = 1'b0;
        end else begin
            mfull = (mq.size() == DEPTH);
            if (m_cur_we) m_pending[m_cur_addr] = 1'b0;
            if (reserve_valid && reserve_addr != 0) m_pending[reserve_addr] = 1'b1;
            have = 1'b0;
            w = '0;
            if (alu_valid && !mfull) begin
                w = {alu_addr, alu_data};
                have = 1'b1;
            end else if (mq.size() != 0) begin
                w = mq.pop_front();
                have = 1'b1;
            end
            if (mem_valid && !mfull) mq.push_back({mem_addr, mem_data});
            m_cur_we = have && (w[AW+DW-1:DW] != 0);
            if (m_cur_we) begin
                m_cur_addr = w[AW+DW-1:DW];
                m_cur_data = w[DW-1:0];
                exp_q.push_back(w);
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin : monitor
        logic [AW+DW-1:0] e;
        int sz;
        sz = mq.size();
        check("alu_ready", alu_ready, rst_n && (sz < DEPTH));
        check("mem_ready", mem_ready, rst_n && (sz < DEPTH));
        check("pending", pending, m_pending);
        check("occ_state", occ_state, (sz == 0) ? 2'd0 : (sz == DEPTH) ? 2'd2 : 2'd1);
        check("rf_we", rf_write_enable, m_cur_we);
        if (rf_write_enable) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_entry", {rf_write_addr, rf_data_in}, e);
            end
        end else if (exp_q.size() != 0) begin
            check("wr_missing", 0, 1);
            void'(exp_q.pop_front());
        end
`ifdef WB_FORWARD_EN
        check("fwd_hit", fwd_hit, m_cur_we && (m_cur_addr == fwd_addr) && (fwd_addr != 0));
        if (m_cur_we) check("fwd_data", fwd_data, m_cur_data);
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid     = 1'b0;
        mem_valid     = 1'b0;
        reserve_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic rand_phase(input int cycles, input int alu_pct, input int mem_pct,
                              input int rst_pm);
        logic acc;
        logic macc;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            acc  = alu_valid && alu_ready;
            macc = mem_valid && mem_ready;
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 999) >= rst_pm);
            if (!alu_valid || acc) begin
                alu_valid = ($urandom_range(0, 99) < alu_pct);
                alu_addr  = rand_addr();
                alu_data  = $urandom;
            end
            if (!mem_valid || macc) begin
                mem_valid = ($urandom_range(0, 99) < mem_pct);
                mem_addr  = rand_addr();
                mem_data  = $urandom;
            end
            reserve_valid = ($urandom_range(0, 99) < 30);
            reserve_addr  = rand_addr();
`ifdef WB_FORWARD_EN
            fwd_addr = rand_addr();
`endif
        end
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0; reserve_addr = '0;
        idle_inputs();
`ifdef WB_FORWARD_EN
        fwd_addr = 5'd5;
`endif
        tick();
        tick();
        @(negedge clk);
        check("rst_we", rf_write_enable, 0);
        check("rst_addr", rf_write_addr, 0);
        check("rst_data", rf_data_in, 0);
        check("rst_pending", pending, 0);
        tick();
        rst_n = 1'b1;

        // Single ALU write, one cycle of latency.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hA5;
        @(negedge clk);
        check("a5_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("a5_we", rf_write_enable, 1);
        check("a5_addr", rf_write_addr, 5);
        check("a5_data", rf_data_in, 32'hA5);
`ifdef WB_FORWARD_EN
        check("a5_fwd_hit", fwd_hit, 1);
        check("a5_fwd_data", fwd_data, 32'hA5);
`endif
        tick();
        @(negedge clk);
        check("a5_we_drop", rf_write_enable, 0);

        // Four loads with no ALU traffic.
        for (int i = 1; i <= 4; i++) begin
            mem_valid = 1'b1; mem_addr = AW'(i); mem_data = DW'(i * 10);
            @(negedge clk);
            check("load_ready", mem_ready, 1);
            tick();
        end
        idle(6);

        // ALU held busy while loads fill the buffer; full buffer steals the slot.
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        for (int i = 1; i <= 4; i++) begin
            mem_valid = 1'b1; mem_addr = AW'(i); mem_data = DW'(i * 10);
            tick();
        end
        mem_valid = 1'b0;
        @(negedge clk);
        check("full_alu_ready", alu_ready, 0);
        check("full_mem_ready", mem_ready, 0);
        tick();
        @(negedge clk);
        check("full_head_addr", rf_write_addr, 1);
        check("full_head_data", rf_data_in, 10);
        idle(8);

        // Scoreboard set / retire / same-cycle reserve on retire.
        reserve_valid = 1'b1; reserve_addr = 5'd9;
        tick();
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        @(negedge clk);
        check("p9_set", pending[9], 1);
        tick();
        alu_valid = 1'b0;
        reserve_valid = 1'b1; reserve_addr = 5'd9;
        tick();
        reserve_valid = 1'b0;
        @(negedge clk);
        check("p9_set_wins", pending[9], 1);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h98;
        tick();
        alu_valid = 1'b0;
        tick();
        @(negedge clk);
        check("p9_cleared", pending[9], 0);

        // x0 result and x0 reserve.
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF;
        reserve_valid = 1'b1; reserve_addr = 5'd0;
        @(negedge clk);
        check("x0_ready", alu_ready, 1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("x0_no_we", rf_write_enable, 0);
        check("x0_pending0", pending[0], 0);
        idle(2);

        // Reset while the buffer holds three loads.
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        reserve_valid = 1'b1; reserve_addr = 5'd4;
        for (int i = 1; i <= 3; i++) begin
            mem_valid = 1'b1; mem_addr = AW'(i + 10); mem_data = DW'(i);
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_mem_ready_low", mem_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_we0", rf_write_enable, 0);
        check("rstmid_pending", pending, 0);
        check("rstmid_mem_ready", mem_ready, 1);
        tick();
        @(negedge clk);
        check("rstmid_we1", rf_write_enable, 0);
        idle(2);

        // Randomized traffic: light, heavy, load-dominated with occasional resets.
        rand_phase(800, 30, 30, 0);
        rand_phase(800, 85, 80, 0);
        rand_phase(800, 20, 90, 5);
        idle(DEPTH + 4);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
